// File: rtl/cw305_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cw305_seq_pkg
//  Purpose  : Shared encodings for the CW305 core run sequencer: FSM state
//             codes, run status codes and the default result width (the
//             crypto cipher width of the register interface).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cw305_seq_pkg;

    // Width of the crypto cipher bus on the CW305 register interface.
    localparam int CIPHER_W         = 128;
    localparam int DEFAULT_RESULT_W = CIPHER_W;

    // Sequencer state encoding.
    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] seq_state_t;

    localparam seq_state_t S_IDLE   = 3'd0;
    localparam seq_state_t S_HOLD   = 3'd1;
    localparam seq_state_t S_RUN    = 3'd2;
    localparam seq_state_t S_FINISH = 3'd3;
    localparam seq_state_t S_DONE   = 3'd4;

    // Run outcome reported on the status output.
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TRAP    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage
`default_nettype wire

// File: rtl/cw305_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : cw305_sat_counter
//  Purpose  : Saturating up-counter with synchronous clear and enable, plus a
//             look-ahead compare that flags when the next count would reach
//             or pass a limit (limit 0 disables the compare).
//  Ports    : clk        - clock, rising edge
//             rst        - synchronous active-high reset
//             i_clear    - clear count to zero (wins over enable)
//             i_enable   - count this cycle
//             i_limit    - compare limit, 0 = never
//             o_count    - current count
//             o_at_limit - count+1 >= limit and limit != 0
//  Revision : 1.0  initial release
// ============================================================================
module cw305_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_count,
    output logic             o_at_limit
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_count_inc;
    logic             w_saturated;

    // One bit wider so the look-ahead compare is still correct at all-ones.
    assign w_count_inc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
    assign w_saturated = &r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_saturated) begin
            r_count <= w_count_inc[CNT_W-1:0];
        end
    end

    assign o_count    = r_count;
    assign o_at_limit = (i_limit != '0) && (w_count_inc >= {1'b0, i_limit});

endmodule
`default_nettype wire

// File: rtl/cw305_core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cw305_core_sequencer
//  Purpose  : Sequences one run of the soft RISC-V core behind the CW305
//             crypto register interface: reset hold, run with scope trigger,
//             end on done/trap/timeout, capture result and status, report
//             done back to the register block.
//  Ports    : clk           - crypto clock, rising edge
//             reset         - synchronous active-high reset
//             start         - run request level, a run begins on 0->1
//             timeout_limit - max RUN cycles, 0 disables the timeout
//             core_resetn   - active-low reset to the core wrapper
//             core_done     - core program completion
//             core_trap     - core trap indication
//             core_result   - result bus from the core wrapper
//             result        - result captured at end of run
//             status        - 00 ok, 01 trap, 10 timeout
//             cycle_count   - RUN cycles of the last/current run
//             busy          - run in progress (HOLD, RUN, FINISH)
//             done          - idle / ready (IDLE, DONE)
//             trigger       - scope trigger, high exactly while in RUN
//  Revision : 1.0  initial release
// ============================================================================
module cw305_core_sequencer
    import cw305_seq_pkg::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int CNT_W      = 32,
    parameter int RESULT_W   = DEFAULT_RESULT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CNT_W-1:0]    timeout_limit,
    output logic                core_resetn,
    input  logic                core_done,
    input  logic                core_trap,
    input  logic [RESULT_W-1:0] core_result,
    output logic [RESULT_W-1:0] result,
    output logic [1:0]          status,
    output logic [CNT_W-1:0]    cycle_count,
    output logic                busy,
    output logic                done,
    output logic                trigger
);

    // Hold counter counts RST_CYCLES-1 down to 0, giving RST_CYCLES HOLD cycles.
    localparam logic [7:0] c_hold_load = 8'(RST_CYCLES - 1);

    seq_state_t            r_state;
    seq_state_t            w_state_next;
    logic                  r_start_q;
    logic                  w_start_edge;
    logic                  w_launch;
    logic                  w_run_exit;
    logic [1:0]            w_exit_status;
    logic [7:0]            r_hold_cnt;
    logic [RESULT_W-1:0]   r_result;
    logic [1:0]            r_status;
    logic                  w_at_limit;

    assign w_start_edge = start & ~r_start_q;

    // Done outranks trap, trap outranks timeout.
    assign w_exit_status = core_done ? ST_OK : (core_trap ? ST_TRAP : ST_TIMEOUT);

    cw305_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_launch),
        .i_enable   (r_state == S_RUN),
        .i_limit    (timeout_limit),
        .o_count    (cycle_count),
        .o_at_limit (w_at_limit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_run_exit   = 1'b0;
        core_resetn  = 1'b0;
        trigger      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = 1'b1;
                if (w_start_edge) begin
                    w_state_next = S_HOLD;
                    w_launch     = 1'b1;
                end
            end
            S_HOLD: begin
                busy = 1'b1;
                if (r_hold_cnt == 8'd0) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy        = 1'b1;
                core_resetn = 1'b1;
                trigger     = 1'b1;
                if (core_done || core_trap || w_at_limit) begin
                    w_state_next = S_FINISH;
                    w_run_exit   = 1'b1;
                end
            end
            S_FINISH: begin
                busy         = 1'b1;
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers: start history, hold count, captured outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_q  <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_result   <= '0;
            r_status   <= ST_OK;
        end else begin
            r_start_q <= start;
            if (w_launch) begin
                r_hold_cnt <= c_hold_load;
            end else if (r_state == S_HOLD) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
            if (w_run_exit) begin
                r_status <= w_exit_status;
            end
            if (r_state == S_FINISH) begin
                r_result <= core_result;
            end
        end
    end

    assign result = r_result;
    assign status = r_status;

endmodule
`default_nettype wire

// File: doc/cw305_core_sequencer.md
Name: cw305_core_sequencer

Overview:
- Sequences one run of the soft RISC-V core behind the CW305 crypto register interface, clocked from the crypto clock.
- On a start edge from the register block, it performs the following in order:
  - holds the core in reset for a fixed number of cycles;
  - releases it and raises the capture trigger;
  - waits for completion, trap or timeout;
  - captures the result word and a status code;
  - reports done to the register block.
- Replaces the direct start/busy wiring between the register block and the core wrapper.

Parameters:
- RST_CYCLES, 16: clock cycles core_resetn is held low before the run (legal range 1..255).
- CNT_W, 32: width of the run-cycle counter and of timeout_limit.
- RESULT_W, 128: width of the captured result; equals the crypto cipher width.

Ports:
- clk  in  1  crypto clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level from the register block; a run begins on its 0->1 transition.
- timeout_limit  in  CNT_W  maximum run cycles; 0 disables the timeout.
- core_resetn  out  1  active-low reset to the core wrapper.
- core_done  in  1  core signals program completion (single-cycle or level).
- core_trap  in  1  core trap indication.
- core_result  in  RESULT_W  result bus from the core wrapper.
- result  out  RESULT_W  result captured at end of run.
- status  out  2  run outcome: 00 ok, 01 trap, 10 timeout, 11 never produced.
- cycle_count  out  CNT_W  number of RUN cycles of the last or current run.
- busy  out  1  high from the accepted start edge until DONE is entered.
- done  out  1  high in DONE; also used as ready.
- trigger  out  1  scope trigger; high exactly while in RUN.

Behaviour:
- Reset values:
  - core_resetn=0, result=0, status=00, cycle_count=0.
  - busy=0, done=1, trigger=0.
  - State=IDLE, start_q=0 (start_q is the registered copy of start).
- Start edge: start_edge = start & ~start_q. start_q is updated every cycle in every state. Start edges are ignored unless the state is IDLE or DONE.
- State IDLE (also entered after reset):
  - core_resetn=0, done=1.
  - On start_edge: go to HOLD; load hold_cnt=RST_CYCLES-1; clear cycle_count; busy=1 and done=0 from the next cycle.
- State HOLD:
  - core_resetn=0; hold_cnt decrements each cycle.
  - When hold_cnt==0: go to RUN. core_resetn=1 and trigger=1 are registered on the same edge.
  - The core is therefore held in reset for exactly RST_CYCLES cycles.
- State RUN:
  - core_resetn=1, trigger=1; cycle_count increments each cycle, saturating at all-ones.
  - Exit conditions are evaluated on registered inputs, in this priority order:
    - core_done -> FINISH, status=00;
    - else core_trap -> FINISH, status=01;
    - else timeout_limit!=0 and cycle_count+1 >= timeout_limit -> FINISH, status=10.
  - Simultaneous done and trap: done wins.
- State FINISH (1 cycle):
  - result <= core_result; trigger=0; core_resetn=0 (core is parked in reset).
  - Next state is DONE.
- State DONE:
  - done=1, busy=0; result, status and cycle_count are held stable.
  - core_resetn stays 0.
  - A start_edge starts a new run exactly as from IDLE.
- Latency:
  - start edge to core_resetn rising: RST_CYCLES+1 cycles.
  - core_done to done rising: 2 cycles (RUN->FINISH->DONE).
- start held high after a run does not retrigger; it must return low first.
- timeout_limit is sampled continuously; changing it mid-run takes effect immediately.
- Reset asserted mid-run: next edge goes to IDLE with all outputs at reset values; the core is held in reset.
- cycle_count saturation does not itself end a run.

Decomposition:
- Package cw305_seq_pkg holds:
  - the state encoding (IDLE, HOLD, RUN, FINISH, DONE);
  - the status codes (ST_OK=2'b00, ST_TRAP=2'b01, ST_TIMEOUT=2'b10);
  - RESULT_W defaulted from the crypto cipher width.
- Sub-module cw305_sat_counter: synchronous clear, enable, saturating, CNT_W wide, with a compare-against-limit output. Used for cycle_count and the timeout check.

Test Plan:
- Basic run:
  - Stimulus: RST_CYCLES=4; start 0->1; core_done pulses 10 cycles after core_resetn rises; core_result=128'hDEAD...BEEF.
  - Required response: core_resetn low for 4 cycles after the edge; trigger high 10 cycles; done rises 2 cycles after core_done; status=00; cycle_count=10; result matches.
- Trap:
  - Stimulus: core_trap asserted 5 RUN cycles in.
  - Required response: status=01; cycle_count=5; trigger falls next cycle; core_resetn=0 in DONE.
- Timeout:
  - Stimulus: timeout_limit=100; core_done never asserted.
  - Required response: status=10; cycle_count=100; done high.
  - With timeout_limit=0 the run continues past 1000 cycles.
- Simultaneous events:
  - Stimulus: core_done and core_trap asserted in the same cycle.
  - Required response: status=00.
  - Separately, a start edge during RUN is ignored: busy stays high and cycle_count is not cleared.
- Re-run and hold:
  - Stimulus: start held high through DONE.
  - Required response: no second run.
  - Then start 1->0->1: a new run begins; cycle_count is cleared to 0 at the start of HOLD.
- Reset mid-run:
  - Stimulus: reset asserted at RUN cycle 7.
  - Required response: next cycle core_resetn=0, trigger=0, busy=0, done=1, status=00, cycle_count=0.
